// File: rtl/onewire_slave.sv
// Single-drop 1-wire responder: reset/presence, LSB-first byte receive, Read ROM (0x33) reply.
// All slot timing is derived from the CPU (cycles per microsecond) parameter.
module onewire_slave #(
    parameter int unsigned CPU = 33,
    parameter logic [63:0] ROM = 64'h5A00_0000_0000_0128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic       bus_rst,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       busy
);

    localparam logic [15:0] RstLast  = 16'(400 * CPU - 1);
    localparam logic [15:0] PwLast   = 16'(30 * CPU - 1);
    localparam logic [15:0] PresLast = 16'(120 * CPU - 1);
    localparam logic [15:0] SmpLast  = 16'(15 * CPU - 1);
    localparam logic [15:0] HoldLast = 16'(30 * CPU - 1);

    typedef enum logic [2:0] {StIdle, StPresWait, StPres, StCmd, StRom, StData} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, line_q, line_d;
    logic [15:0] lowcnt_q, lowcnt_d, tmr_q, tmr_d;
    logic        act_q, act_d;
    logic [6:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [63:0] rom_sh_q, rom_sh_d;
    logic        owr_e_q, owr_e_d, bus_rst_q, bus_rst_d, rx_vld_q, rx_vld_d, busy_q, busy_d;
    logic        fall, rise;
    logic [7:0]  new_byte;

    assign fall     = line_q & ~sync2_q;
    assign rise     = ~line_q & sync2_q;
    assign new_byte = {sync2_q, rx_sh_q[7:1]};

    always_comb begin
        sync1_d   = owr_i;
        sync2_d   = sync1_q;
        line_d    = sync2_q;
        state_d   = state_q;
        lowcnt_d  = lowcnt_q;
        tmr_d     = tmr_q;
        act_d     = act_q;
        bitcnt_d  = bitcnt_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rom_sh_d  = rom_sh_q;
        owr_e_d   = owr_e_q;
        bus_rst_d = 1'b0;
        rx_vld_d  = 1'b0;

        if (fall) begin
            lowcnt_d = '0;
        end else if (!sync2_q && lowcnt_q != 16'hFFFF) begin
            lowcnt_d = lowcnt_q + 16'd1;
        end

        // act_q: presence timer armed, slot sample pending, or ROM bit hold running
        if (act_q || state_q == StPres) begin
            tmr_d = tmr_q + 16'd1;
        end

        unique case (state_q)
            StIdle: ;
            StPresWait: begin
                if (!act_q && rise) begin
                    act_d = 1'b1;
                    tmr_d = '0;
                end else if (act_q && tmr_q == PwLast) begin
                    act_d   = 1'b0;
                    tmr_d   = '0;
                    owr_e_d = 1'b1;
                    state_d = StPres;
                end
            end
            StPres: begin
                if (tmr_q == PresLast) begin
                    owr_e_d  = 1'b0;
                    bitcnt_d = '0;
                    state_d  = StCmd;
                end
            end
            StCmd, StData: begin
                // A new falling edge before the sample point discards the pending slot
                if (fall) begin
                    act_d = 1'b1;
                    tmr_d = '0;
                end else if (act_q && tmr_q == SmpLast) begin
                    act_d    = 1'b0;
                    rx_sh_d  = new_byte;
                    bitcnt_d = bitcnt_q + 7'd1;
                    if (bitcnt_q == 7'd7) begin
                        bitcnt_d = '0;
                        if (state_q == StCmd && new_byte == 8'h33) begin
                            rom_sh_d = ROM;
                            state_d  = StRom;
                        end else begin
                            rx_vld_d  = 1'b1;
                            rx_data_d = new_byte;
                            state_d   = StData;
                        end
                    end
                end
            end
            StRom: begin
                if (!act_q && fall) begin
                    act_d   = 1'b1;
                    tmr_d   = '0;
                    owr_e_d = ~rom_sh_q[0];
                end else if (act_q && tmr_q == HoldLast) begin
                    act_d    = 1'b0;
                    owr_e_d  = 1'b0;
                    rom_sh_d = rom_sh_q >> 1;
                    bitcnt_d = bitcnt_q + 7'd1;
                    if (bitcnt_q == 7'd63) begin
                        bitcnt_d = '0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!sync2_q && !fall && lowcnt_q == RstLast) begin
            bus_rst_d = 1'b1;
            owr_e_d   = 1'b0;
            rx_vld_d  = 1'b0;
            act_d     = 1'b0;
            tmr_d     = '0;
            bitcnt_d  = '0;
            state_d   = StPresWait;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            line_q    <= 1'b1;
            state_q   <= StIdle;
            lowcnt_q  <= '0;
            tmr_q     <= '0;
            act_q     <= 1'b0;
            bitcnt_q  <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rom_sh_q  <= '0;
            owr_e_q   <= 1'b0;
            bus_rst_q <= 1'b0;
            rx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            line_q    <= line_d;
            state_q   <= state_d;
            lowcnt_q  <= lowcnt_d;
            tmr_q     <= tmr_d;
            act_q     <= act_d;
            bitcnt_q  <= bitcnt_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rom_sh_q  <= rom_sh_d;
            owr_e_q   <= owr_e_d;
            bus_rst_q <= bus_rst_d;
            rx_vld_q  <= rx_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign owr_e   = owr_e_q;
    assign bus_rst = bus_rst_q;
    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: master model on a wired-AND line, scoreboard for received bytes.
// Uses a reduced cycles-per-microsecond value to keep the run short.
module tb_onewire_slave;

    localparam int          CPU   = 4;
    localparam logic [63:0] RomId = 64'h5A00_0000_0000_0128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_low;
    logic       owr_i;
    logic       owr_e;
    logic       bus_rst;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int brst_cnt = 0;
    int rx_cnt   = 0;
    logic brst_prev = 1'b0;
    logic vld_prev  = 1'b0;
    logic [7:0] exp_q[$];

    assign owr_i = ~(m_low | owr_e);

    always #5 clk = ~clk;

    onewire_slave #(.CPU(CPU), .ROM(RomId)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .owr_i   (owr_i),
        .owr_e   (owr_e),
        .bus_rst (bus_rst),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_vld and checks strobe widths
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_rst) begin
                brst_cnt++;
                check("bus_rst_width", {63'd0, brst_prev}, 64'd0);
            end
            if (rx_vld) begin
                rx_cnt++;
                check("rx_vld_width", {63'd0, vld_prev}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", {56'd0, rx_data}, 64'hFFFF);
                end else begin
                    check("rx_data", {56'd0, rx_data}, {56'd0, exp_q.pop_front()});
                end
            end
        end
        brst_prev = bus_rst;
        vld_prev  = rx_vld;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input logic b);
        m_low = 1'b1;
        tick(b ? 6 * CPU : 60 * CPU);
        m_low = 1'b0;
        tick(b ? 59 * CPU : 5 * CPU);
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) write_bit(b[i]);
    endtask

    task automatic read_bit(output logic v);
        m_low = 1'b1;
        tick(2 * CPU);
        m_low = 1'b0;
        tick(13 * CPU);
        v = owr_i;
        tick(50 * CPU);
    endtask

    task automatic do_reset(input string tag);
        int c0;
        int n_rst;
        int n_rise;
        int n_wid;
        c0     = brst_cnt;
        n_rst  = -1;
        n_rise = -1;
        n_wid  = 0;
        m_low  = 1'b1;
        for (int i = 1; i <= 480 * CPU; i++) begin
            tick(1);
            if (bus_rst && n_rst < 0) n_rst = i;
        end
        m_low = 1'b0;
        check_range({tag, "_bus_rst_at"}, n_rst, 400 * CPU, 400 * CPU + 4);
        check({tag, "_bus_rst_cnt"}, 64'(brst_cnt - c0), 64'd1);
        for (int i = 1; i <= 40 * CPU; i++) begin
            tick(1);
            if (owr_e) begin
                n_rise = i;
                break;
            end
        end
        check_range({tag, "_pres_rise"}, n_rise, 30 * CPU, 30 * CPU + 4);
        while (owr_e && n_wid < 200 * CPU) begin
            tick(1);
            n_wid++;
        end
        check({tag, "_pres_width"}, 64'(n_wid), 64'(120 * CPU));
        tick(10 * CPU);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    endtask

    initial begin
        logic [63:0] id;
        logic        v;
        int          rx0;
        rst_n = 1'b0;
        m_low = 1'b0;
        tick(5);
        check("rst_owr_e", {63'd0, owr_e}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        tick(1000 * CPU);
        check("idle_outs", {52'd0, owr_e, bus_rst, rx_vld, busy, rx_data}, 64'd0);
        check("idle_no_bus_rst", 64'(brst_cnt), 64'd0);

        do_reset("t2");

        do_reset("t3");
        exp_q.push_back(8'hCC);
        write_byte(8'hCC);
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        tick(10 * CPU);
        check("t3_rx_cnt", 64'(rx_cnt), 64'd2);

        do_reset("t4");
        write_byte(8'h33);
        for (int i = 0; i < 64; i++) begin
            read_bit(v);
            id[i] = v;
        end
        check("t4_rom_id", id, RomId);
        check("t4_busy_after", {63'd0, busy}, 64'd0);

        do_reset("t5a");
        rx0 = rx_cnt;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        do_reset("t5b");
        check("t5_no_rx_vld", 64'(rx_cnt - rx0), 64'd0);
        exp_q.push_back(8'h0F);
        write_byte(8'h0F);

        // Runt: the next slot's falling edge lands before the runt's sample point
        m_low = 1'b1;
        tick(5 * CPU);
        m_low = 1'b0;
        tick(5 * CPU);
        exp_q.push_back(8'h81);
        write_byte(8'h81);

        tick(20 * CPU);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        check("rx_total", 64'(rx_cnt), 64'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
